// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the writeback-port arbiter: requester count, source
// index encoding and the global register-file widths.
package wb_port_arbiter_pkg;

    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;

    localparam int unsigned WB_NREQ  = 3;
    localparam int unsigned WB_SRC_W = $clog2(WB_NREQ);

    localparam logic [WB_SRC_W-1:0] WB_SRC_ALU = WB_SRC_W'(0);
    localparam logic [WB_SRC_W-1:0] WB_SRC_LSU = WB_SRC_W'(1);
    localparam logic [WB_SRC_W-1:0] WB_SRC_MDU = WB_SRC_W'(2);

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after i_last, wrapping.
// Produces a one-hot grant, its encoded index and an any-request flag.
module wb_port_arbiter_rr_pick #(
    parameter  int unsigned N  = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned j;
            j = (32'(i_last) + k) % N;
            if (!o_any && i_req[j]) begin
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single regfile write port among NREQ writeback sources using
// round-robin arbitration; registered write/commit one cycle after fire.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ   = WB_NREQ,
    parameter  int unsigned ADDR_W = WB_ADDR_W,
    parameter  int unsigned DATA_W = WB_DATA_W,
    parameter  int unsigned CNT_W  = 32,
    localparam int unsigned SRC_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_wen,
    input  logic [NREQ*ADDR_W-1:0]   req_waddr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    input  logic                     wb_stall,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic                     commit_valid,
    output logic [SRC_W-1:0]         commit_src,
    output logic [CNT_W-1:0]         conflict_cnt
);

    logic [SRC_W-1:0]  r_last_grant;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_commit_valid;
    logic [SRC_W-1:0]  r_commit_src;
    logic [CNT_W-1:0]  r_conflict_cnt;

    logic [NREQ-1:0]   w_gnt;
    logic [SRC_W-1:0]  w_idx;
    logic              w_any;
    logic              w_fire;
    logic              w_sel_wen;
    logic [ADDR_W-1:0] w_sel_waddr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_conflict;

    wb_port_arbiter_rr_pick #(
        .N(NREQ)
    ) u_rr_pick (
        .i_req  (req_valid),
        .i_last (r_last_grant),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Grants are withheld during reset and stall so nothing can fire then.
    assign w_fire     = w_any & ~reset & ~wb_stall;
    assign req_ready  = (reset | wb_stall) ? '0 : w_gnt;
    assign w_conflict = ($countones(req_valid) > 1) & ~wb_stall;

    always_comb begin
        w_sel_wen   = 1'b0;
        w_sel_waddr = '0;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_idx == SRC_W'(i)) begin
                w_sel_wen   = req_wen[i];
                w_sel_waddr = req_waddr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Payload registers hold when nothing fires; strobes drop to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant   <= SRC_W'(NREQ - 1);
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_commit_valid <= 1'b0;
            r_commit_src   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_commit_valid <= w_fire;
            r_rf_we        <= w_fire & w_sel_wen & (w_sel_waddr != '0);
            if (w_fire) begin
                r_last_grant <= w_idx;
                r_commit_src <= w_idx;
                r_rf_waddr   <= w_sel_waddr;
                r_rf_wdata   <= w_sel_wdata;
            end
            if (w_conflict && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
            end
        end
    end

    assign rf_we        = r_rf_we;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign commit_valid = r_commit_valid;
    assign commit_src   = r_commit_src;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios plus a random soak.
module tb_wb_port_arbiter;

    localparam int unsigned NREQ   = 3;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned SRC_W  = 2;

    logic                   clk;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_wen;
    logic [NREQ*ADDR_W-1:0] req_waddr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic                   wb_stall;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
    logic                   commit_valid;
    logic [SRC_W-1:0]       commit_src;
    logic [CNT_W-1:0]       conflict_cnt;

    wb_port_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_waddr    (req_waddr),
        .req_wdata    (req_wdata),
        .wb_stall     (wb_stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .commit_valid (commit_valid),
        .commit_src   (commit_src),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              cv;
        logic [SRC_W-1:0]  src;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_cmp;
    int   n_bad;

    logic [SRC_W-1:0]  m_last;
    logic [SRC_W-1:0]  m_src;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;
    logic [CNT_W-1:0]  m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic wen, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_wen[i]                   = wen;
        req_waddr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    // One clock: check ready, push predicted outputs, clock, pop and compare.
    task automatic step();
        logic [NREQ-1:0] er;
        int              w;
        exp_t            e;
        #1;
        er = '0;
        w  = -1;
        if (!reset && !wb_stall) begin
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (int'(m_last) + k) % NREQ;
                if (w < 0 && req_valid[j]) w = j;
            end
        end
        if (w >= 0) er[w] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        e.cv = 1'b0;
        e.we = 1'b0;
        if (reset) begin
            m_last  = SRC_W'(NREQ - 1);
            m_src   = '0;
            m_waddr = '0;
            m_wdata = '0;
            m_cnt   = '0;
        end else begin
            if ($countones(req_valid) >= 2 && !wb_stall && m_cnt != '1) m_cnt = m_cnt + 1;
            if (w >= 0) begin
                e.cv    = 1'b1;
                m_src   = SRC_W'(w);
                m_last  = SRC_W'(w);
                m_waddr = req_waddr[w*ADDR_W +: ADDR_W];
                m_wdata = req_wdata[w*DATA_W +: DATA_W];
                e.we    = req_wen[w] && (m_waddr != '0);
                grant_log.push_back(w);
            end
        end
        e.src   = m_src;
        e.waddr = m_waddr;
        e.wdata = m_wdata;
        e.cnt   = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("commit_valid", 64'(commit_valid), 64'(e.cv));
        check("commit_src",   64'(commit_src),   64'(e.src));
        check("rf_we",        64'(rf_we),        64'(e.we));
        check("rf_waddr",     64'(rf_waddr),     64'(e.waddr));
        check("rf_wdata",     64'(rf_wdata),     64'(e.wdata));
        check("conflict_cnt", 64'(conflict_cnt), 64'(e.cnt));
    endtask

    initial begin
        logic [CNT_W-1:0] cnt0;
        n_cmp     = 0;
        n_bad     = 0;
        m_last    = SRC_W'(NREQ - 1);
        m_src     = '0;
        m_waddr   = '0;
        m_wdata   = '0;
        m_cnt     = '0;
        reset     = 1'b1;
        wb_stall  = 1'b0;
        req_valid = '0;
        req_wen   = '0;
        req_waddr = '0;
        req_wdata = '0;
        @(negedge clk);

        // Reset held with all requesters valid
        set_req(0, 1'b1, 5'd1, 32'h0000_1111);
        set_req(1, 1'b1, 5'd2, 32'h0000_2222);
        set_req(2, 1'b1, 5'd3, 32'h0000_3333);
        req_valid = 3'b111;
        step();
        step();
        check("rst_cnt", 64'(conflict_cnt), 64'd0);
        check("rst_cv",  64'(commit_valid), 64'd0);
        reset     = 1'b0;
        req_valid = 3'b000;
        step();

        // Single source, requester 1
        set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        step();
        check("single_src",   64'(commit_src),   64'd1);
        check("single_data",  64'(rf_wdata),    64'hDEAD_BEEF);
        check("single_cnt",   64'(conflict_cnt), 64'd0);
        req_valid = 3'b000;
        step();

        // Round robin after a grant to 1, start pointer at 2: force back to 0 first
        req_valid = 3'b100;
        step();
        grant_log.delete();
        cnt0      = m_cnt;
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) step();
        for (int i = 0; i < 6; i++) check("rr_order", 64'(grant_log[i]), 64'(i % 3));
        check("rr_cnt", 64'(conflict_cnt), 64'(cnt0 + 6));

        // x0 write and commit-only op
        req_valid = 3'b001;
        set_req(0, 1'b1, 5'd0, 32'hAAAA_0000);
        step();
        check("x0_we", 64'(rf_we), 64'd0);
        check("x0_cv", 64'(commit_valid), 64'd1);
        set_req(0, 1'b0, 5'd7, 32'hBBBB_0007);
        step();
        check("nowen_we", 64'(rf_we), 64'd0);
        check("nowen_addr", 64'(rf_waddr), 64'd7);

        // Stall with 101 valid; last grant is 0 so release goes to 2 then 0
        set_req(0, 1'b1, 5'd9,  32'h0000_0009);
        set_req(2, 1'b1, 5'd10, 32'h0000_000A);
        req_valid = 3'b101;
        wb_stall  = 1'b1;
        cnt0      = m_cnt;
        for (int i = 0; i < 3; i++) step();
        check("stall_cnt", 64'(conflict_cnt), 64'(cnt0));
        check("stall_cv",  64'(commit_valid), 64'd0);
        wb_stall = 1'b0;
        grant_log.delete();
        step();
        step();
        check("resume_0", 64'(grant_log[0]), 64'd2);
        check("resume_1", 64'(grant_log[1]), 64'd0);

        // Reset mid-operation: grant to 2 then reset
        req_valid = 3'b100;
        step();
        check("pre_rst_src", 64'(commit_src), 64'd2);
        reset = 1'b1;
        step();
        check("mid_rst_cnt", 64'(conflict_cnt), 64'd0);
        check("mid_rst_addr", 64'(rf_waddr), 64'd0);
        reset = 1'b0;
        req_valid = 3'b111;
        grant_log.delete();
        step();
        check("post_rst_grant", 64'(grant_log[0]), 64'd0);

        // Random soak
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            wb_stall  = ($urandom_range(0, 5) == 0);
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'($urandom), ADDR_W'($urandom_range(0, 7)), $urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
